// File: rtl/uart_prog_loader.sv
// UART program loader: sends a sync byte, receives a length-prefixed big-endian word image, writes it to instruction memory.
// Optional trailing XOR checksum of the data bytes is enabled by defining UART_PROG_LOADER_CSUM_EN.
module uart_prog_loader #(
    parameter int          ADDR_W    = 14,
    parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              imem_we,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [3:0] {
        IDLE,
        SEND_SYNC,
        WAIT_TX,
        LEN,
        DATA,
`ifdef UART_PROG_LOADER_CSUM_EN
        CSUM,
`endif
        TRAILER,
        DONE,
        ERR
    } state_t;

`ifdef UART_PROG_LOADER_CSUM_EN
    localparam state_t POST_DATA = CSUM;
`else
    localparam state_t POST_DATA = TRAILER;
`endif

    localparam logic [32:0]     CAPACITY = 33'd1 << ADDR_W;
    localparam logic [ADDR_W:0] WC_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t      state;
    logic        guard;
    logic [1:0]  byte_cnt;
    logic [31:0] len_r;
    logic [23:0] shift_r;
`ifdef UART_PROG_LOADER_CSUM_EN
    logic [7:0]  csum;
`endif

    logic [31:0]     len_full;
    logic [31:0]     word_full;
    logic [ADDR_W:0] wc_next;
    logic            last_word;

    always_comb begin
        len_full  = {len_r[23:0], rx_data};
        word_full = {shift_r, rx_data};
        wc_next   = word_count + WC_ONE;
        last_word = (32'(wc_next) == len_r);
        busy      = !(state inside {IDLE, DONE, ERR});
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch below reads the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            guard      <= 1'b0;
            byte_cnt   <= 2'd0;
            len_r      <= 32'd0;
            shift_r    <= 24'd0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            imem_addr  <= '0;
            imem_din   <= 32'd0;
            imem_we    <= 1'b0;
            word_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef UART_PROG_LOADER_CSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            imem_we  <= 1'b0;

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= SEND_SYNC;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
                        byte_cnt   <= 2'd0;
                        len_r      <= 32'd0;
                        shift_r    <= 24'd0;
`ifdef UART_PROG_LOADER_CSUM_EN
                        csum       <= 8'h00;
`endif
                    end
                end
                SEND_SYNC: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= SYNC_BYTE;
                        guard    <= 1'b1;
                        state    <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    // The transmitter raises tx_busy one cycle after tx_start, so skip that cycle.
                    if (guard)
                        guard <= 1'b0;
                    else if (!tx_busy)
                        state <= LEN;
                end
                LEN: begin
                    if (rx_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        len_r    <= len_full;
                        if (byte_cnt == 2'd3) begin
                            if ({1'b0, len_full} > CAPACITY) begin
                                state <= ERR;
                                error <= 1'b1;
                            end else if (len_full == 32'd0) begin
                                state <= POST_DATA;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift_r  <= word_full[23:0];
`ifdef UART_PROG_LOADER_CSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_din   <= word_full;
                            imem_addr  <= word_count[ADDR_W-1:0];
                            word_count <= wc_next;
                            if (last_word)
                                state <= POST_DATA;
                        end
                    end
                end
`ifdef UART_PROG_LOADER_CSUM_EN
                CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            state <= TRAILER;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                TRAILER: begin
                    if (rx_valid) begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader (small ADDR_W so the capacity boundary is reachable).
// Follows UART_PROG_LOADER_CSUM_EN to insert the checksum byte and run the checksum cases.
module tb_uart_prog_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_din;
    logic          imem_we;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          error;

    uart_prog_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hAA)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .imem_addr  (imem_addr),
        .imem_din   (imem_din),
        .imem_we    (imem_we),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            we_cnt   = 0;
    int            tx_cnt   = 0;
    int            tx_bad   = 0;
    logic [AW-1:0] wa [0:127];
    logic [31:0]   wd [0:127];
    logic [7:0]    csum_acc;

    // Outputs are registered, so the falling edge sees them settled.
    always @(negedge clk) begin
        if (imem_we) begin
            wa[we_cnt] = imem_addr;
            wd[we_cnt] = imem_din;
            we_cnt++;
        end
        if (tx_start) begin
            tx_cnt++;
            if (tx_data !== 8'hAA) tx_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic send(input logic [7:0] b);
        put(b);
        idle(2);
    endtask

    task automatic send_word(input logic [31:0] w, input bit b2b);
        for (int i = 3; i >= 0; i--) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            csum_acc = csum_acc ^ b;
            if (b2b) put(b); else send(b);
        end
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 3; i >= 0; i--) send(n[8*i +: 8]);
    endtask

    task automatic finish_session(input logic [7:0] trailer);
`ifdef UART_PROG_LOADER_CSUM_EN
        send(csum_acc);
`endif
        send(trailer);
        idle(3);
        #2;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for the sync pulse, then emulates the transmitter: busy rises one cycle late,
    // and a stray byte arrives while it is busy (must be dropped).
    task automatic wait_sync(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        check({tag, "_sync_seen"}, 32'(seen), 32'd1);
        csum_acc = 8'h00;
        @(negedge clk);
        tx_busy  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        idle(3);
        tx_busy = 1'b0;
        idle(3);
    endtask

    int base;

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_tx", 32'(tx_cnt), 32'd0);

        // Basic two-word load; a start during the session is ignored.
        base = we_cnt;
        pulse_start();
        wait_sync("basic");
        check("basic_tx_cnt", 32'(tx_cnt), 32'd1);
        check("basic_busy", 32'(busy), 32'd1);
        send_len(32'd2);
        pulse_start();
        send_word(32'h12345678, 1'b0);
        send_word(32'h9ABCDEF0, 1'b0);
        finish_session(8'hAA);
        check("basic_tx_once", 32'(tx_cnt), 32'd1);
        check("basic_done", 32'(done), 32'd1);
        check("basic_error", 32'(error), 32'd0);
        check("basic_busy_end", 32'(busy), 32'd0);
        check("basic_wc", 32'(word_count), 32'd2);
        check("basic_writes", 32'(we_cnt - base), 32'd2);
        check("basic_a0", 32'(wa[base]), 32'd0);
        check("basic_d0", wd[base], 32'h12345678);
        check("basic_a1", 32'(wa[base+1]), 32'd1);
        check("basic_d1", wd[base+1], 32'h9ABCDEF0);

        // Empty image; sync is held off while the transmitter is busy.
        base = we_cnt;
        tx_busy = 1'b1;
        pulse_start();
        #2;
        check("empty_done_cleared", 32'(done), 32'd0);
        idle(5);
        check("empty_sync_held", 32'(tx_cnt), 32'd1);
        tx_busy = 1'b0;
        wait_sync("empty");
        check("empty_tx_cnt", 32'(tx_cnt), 32'd2);
        send_len(32'd0);
        finish_session(8'hAA);
        check("empty_done", 32'(done), 32'd1);
        check("empty_wc", 32'(word_count), 32'd0);
        check("empty_writes", 32'(we_cnt - base), 32'd0);

        // Oversize lengths: 17 words, and a value with only the top byte set.
        base = we_cnt;
        pulse_start();
        wait_sync("over");
        send_len(32'h00000011);
        idle(2); #2;
        check("over_error", 32'(error), 32'd1);
        check("over_done", 32'(done), 32'd0);
        check("over_busy", 32'(busy), 32'd0);
        pulse_start();
        wait_sync("over_hi");
        send_len(32'h01000001);
        idle(2); #2;
        check("over_hi_error", 32'(error), 32'd1);
        check("over_writes", 32'(we_cnt - base), 32'd0);

        // Exactly full capacity, bytes back-to-back.
        base = we_cnt;
        pulse_start();
        wait_sync("full");
        send_len(32'd16);
        for (int i = 0; i < 16; i++) send_word(32'hA0B0C000 | i, 1'b1);
        finish_session(8'hAA);
        check("full_done", 32'(done), 32'd1);
        check("full_error", 32'(error), 32'd0);
        check("full_wc", 32'(word_count), 32'd16);
        check("full_writes", 32'(we_cnt - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_a%0d", i), 32'(wa[base+i]), 32'(i));
            check($sformatf("full_d%0d", i), wd[base+i], 32'hA0B0C000 | i);
        end

        // Bad trailer.
        base = we_cnt;
        pulse_start();
        wait_sync("trl");
        send_len(32'd1);
        send_word(32'h00000001, 1'b0);
        finish_session(8'h55);
        check("trl_error", 32'(error), 32'd1);
        check("trl_done", 32'(done), 32'd0);
        check("trl_writes", 32'(we_cnt - base), 32'd1);
        check("trl_a0", 32'(wa[base]), 32'd0);
        check("trl_d0", wd[base], 32'h00000001);

        // Reset mid-word, then a fresh session.
        base = we_cnt;
        pulse_start();
        wait_sync("rst");
        send_len(32'd2);
        send(8'h11);
        send(8'h22);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #2;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wc", 32'(word_count), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        idle(3);
        check("midrst_writes", 32'(we_cnt - base), 32'd0);
        pulse_start();
        wait_sync("post_rst");
        check("post_rst_tx_cnt", 32'(tx_cnt), 32'd8);
        check("post_rst_wc", 32'(word_count), 32'd0);
        send_len(32'd1);
        send_word(32'hCAFEF00D, 1'b1);
        finish_session(8'hAA);
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_a0", 32'(wa[base]), 32'd0);
        check("post_rst_d0", wd[base], 32'hCAFEF00D);

`ifdef UART_PROG_LOADER_CSUM_EN
        // DE^AD^BE^EF = 0x22.
        pulse_start();
        wait_sync("csum_ok");
        send_len(32'd1);
        send_word(32'hDEADBEEF, 1'b0);
        send(8'h22);
        send(8'hAA);
        idle(3); #2;
        check("csum_ok_done", 32'(done), 32'd1);
        check("csum_ok_error", 32'(error), 32'd0);
        pulse_start();
        wait_sync("csum_bad");
        send_len(32'd1);
        send_word(32'hDEADBEEF, 1'b0);
        send(8'h23);
        idle(2); #2;
        check("csum_bad_error", 32'(error), 32'd1);
        send(8'hAA);
        idle(2); #2;
        check("csum_bad_no_trailer", 32'(done), 32'd0);
`endif

        check("tx_data_sync", 32'(tx_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Receive-side counterpart of the core's UART loader handshake.
- On a load request it transmits the 0xAA sync byte, then accepts a length-prefixed program image from the host over the UART receiver.
- Assembles big-endian 32-bit words and writes them to instruction memory.
- Sits between `uart_rx`/`uart_tx` and the instruction BRAM write port; the core is held in LOAD mode until `done` or `error`.

Parameters:
- ADDR_W, 14, instruction-memory word-address width; capacity is 2**ADDR_W words.
- SYNC_BYTE, 8'hAA, byte sent at session start and expected as the trailer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle load request; honoured only in IDLE, DONE or ERR
- rx_data  in  8  byte from `uart_rx`
- rx_valid  in  1  one-cycle strobe; `rx_data` is valid this cycle
- tx_busy  in  1  `uart_tx` busy
- tx_start  out  1  one-cycle transmit strobe
- tx_data  out  8  byte to transmit
- imem_addr  out  ADDR_W  word address
- imem_din  out  32  write data
- imem_we  out  1  one-cycle write enable
- word_count  out  ADDR_W+1  words written so far in this session
- busy  out  1  high in every state except IDLE, DONE and ERR
- done  out  1  sticky success flag
- error  out  1  sticky failure flag

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0; length register 0; shift register 0.
- Reset mid-session aborts immediately. No imem write issues in the cycle after reset.
- States: IDLE, SEND_SYNC, WAIT_TX, LEN, DATA, CSUM, TRAILER, DONE, ERR.
- IDLE/DONE/ERR + start:
  - go to SEND_SYNC;
  - clear done, error, word_count and the byte counter in the same edge.
- SEND_SYNC:
  - if tx_busy=0, drive tx_start=1 and tx_data=SYNC_BYTE for exactly one cycle, then go to WAIT_TX;
  - otherwise stay.
- WAIT_TX:
  - ignore tx_busy in the first cycle (guard cycle);
  - from the second cycle on, go to LEN on tx_busy=0.
  - Any rx_valid in SEND_SYNC or WAIT_TX is dropped.
- LEN:
  - accept 4 bytes, MSB first, into the length register N (32 bits). On the 4th byte:
  - N > 2**ADDR_W → ERR;
  - N = 0 → CSUM (or TRAILER without the feature);
  - else → DATA.
- DATA:
  - shift bytes MSB first into a 32-bit register; the 2-bit byte counter wraps 3→0;
  - on the 4th byte, next cycle: imem_we=1, imem_din=assembled word, imem_addr=word_count[ADDR_W-1:0]; word_count increments in the same edge;
  - after the Nth word's write → CSUM (or TRAILER).
  - A byte arriving in the same cycle as imem_we is accepted normally; no byte is ever lost.
- TRAILER:
  - next byte == SYNC_BYTE → DONE;
  - anything else → ERR.
- DONE: done=1. ERR: error=1. Both hold until rst or a new start.
- start outside IDLE/DONE/ERR is ignored.
- There is no timeout; the loader waits indefinitely for bytes.
- tx_start is never asserted outside SEND_SYNC.

Optional Feature:
- Macro: UART_PROG_LOADER_CSUM_EN.
- Defined:
  - maintain an 8-bit XOR of every DATA byte (LEN bytes excluded), cleared on start;
  - CSUM state accepts one byte;
  - match → TRAILER; mismatch → ERR, with no trailer consumed.
- Undefined:
  - CSUM state and checksum logic are absent;
  - DATA/LEN transitions go directly to TRAILER.

Test Plan:
- Basic load: rst, start → exactly one tx_start pulse with tx_data=0xAA. Host sends 00 00 00 02, 12 34 56 78, 9A BC DE F0, AA → imem writes addr0=0x12345678, addr1=0x9ABCDEF0; done=1; word_count=2; error=0.
- Empty image: length 00 00 00 00 then AA → done=1, no imem_we pulse, word_count=0.
- Oversize: ADDR_W=4, length 00 00 00 11 → error=1 after the 4th length byte, no imem_we.
- Bad trailer: length 1, word 00000001, trailer 0x55 → one write to addr0, error=1, done=0.
- Back-to-back bytes and reset: rx_valid every cycle during DATA → every word correct. rst asserted after 2 data bytes, then a new start → fresh 0xAA sent and word_count restarts at 0.
- With CSUM_EN: word DE AD BE EF, checksum 0x22 → done. Same word with checksum 0x23 → error, trailer not consumed.
